// File: rtl/csr_counter_responder.sv
// CSR responder for the pipeline request port: mcycle/minstret (lo/hi words),
// their read-only user aliases and mcountinhibit, answered one cycle after each request.
module csr_counter_responder #(
    parameter int CYCLE_W   = 64,
    parameter int INSTRET_W = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        retired,
    input  logic        csr_read,
    input  logic [2:0]  csr_modify,
    input  logic [31:0] csr_wdata,
    input  logic [11:0] csr_addr,
    output logic [31:0] csr_rdata,
    output logic        csr_valid
);

    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MCOUNTINH = 12'h320;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_TIME      = 12'hC01;
    localparam logic [11:0] ADDR_TIMEH     = 12'hC81;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    localparam logic [2:0] MOD_WRITE = 3'd1;
    localparam logic [2:0] MOD_SET   = 3'd2;
    localparam logic [2:0] MOD_CLEAR = 3'd3;

    logic [CYCLE_W-1:0]   mcycle_q, mcycle_d;
    logic [INSTRET_W-1:0] minstret_q, minstret_d;
    logic                 inh_cy_q, inh_cy_d;
    logic                 inh_ir_q, inh_ir_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 valid_q, valid_d;

    logic [63:0] mcycle_ext;
    logic [63:0] minstret_ext;
    logic        is_write;
    logic        is_active;
    logic        hit;
    logic        read_only;
    logic        legal;
    logic        do_write;
    logic        sel_cyc_lo, sel_cyc_hi;
    logic        sel_ins_lo, sel_ins_hi;
    logic        sel_inh;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        cyc_inc;
    logic        ins_inc;
    logic [63:0] cyc_next;
    logic [63:0] ins_next;

    // Counters narrower than 64 bits read as zero-extended; hi-word writes above W fall away on truncation.
    assign mcycle_ext   = 64'(mcycle_q);
    assign minstret_ext = 64'(minstret_q);

    always_comb begin
        is_write   = (csr_modify == MOD_WRITE) || (csr_modify == MOD_SET) ||
                     (csr_modify == MOD_CLEAR);
        is_active  = csr_read || is_write;
        hit        = 1'b1;
        read_only  = 1'b0;
        sel_cyc_lo = 1'b0;
        sel_cyc_hi = 1'b0;
        sel_ins_lo = 1'b0;
        sel_ins_hi = 1'b0;
        sel_inh    = 1'b0;
        old_val    = 32'd0;
        case (csr_addr)
            ADDR_MCYCLE: begin
                sel_cyc_lo = 1'b1;
                old_val    = mcycle_ext[31:0];
            end
            ADDR_MCYCLEH: begin
                sel_cyc_hi = 1'b1;
                old_val    = mcycle_ext[63:32];
            end
            ADDR_MINSTRET: begin
                sel_ins_lo = 1'b1;
                old_val    = minstret_ext[31:0];
            end
            ADDR_MINSTRETH: begin
                sel_ins_hi = 1'b1;
                old_val    = minstret_ext[63:32];
            end
            ADDR_MCOUNTINH: begin
                sel_inh = 1'b1;
                old_val = {29'd0, inh_ir_q, 1'b0, inh_cy_q};
            end
            ADDR_CYCLE, ADDR_TIME: begin
                read_only = 1'b1;
                old_val   = mcycle_ext[31:0];
            end
            ADDR_CYCLEH, ADDR_TIMEH: begin
                read_only = 1'b1;
                old_val   = mcycle_ext[63:32];
            end
            ADDR_INSTRET: begin
                read_only = 1'b1;
                old_val   = minstret_ext[31:0];
            end
            ADDR_INSTRETH: begin
                read_only = 1'b1;
                old_val   = minstret_ext[63:32];
            end
            default: hit = 1'b0;
        endcase
        legal    = is_active && hit && !(read_only && is_write);
        do_write = legal && is_write;
    end

    always_comb begin
        new_val = old_val;
        case (csr_modify)
            MOD_WRITE: new_val = csr_wdata;
            MOD_SET:   new_val = old_val | csr_wdata;
            MOD_CLEAR: new_val = old_val & ~csr_wdata;
            default:   new_val = old_val;
        endcase
    end

    // Increments use this cycle's inhibit bits; an inhibit write only matters from the next cycle.
    always_comb begin
        cyc_inc  = !inh_cy_q;
        ins_inc  = retired && !inh_ir_q;

        cyc_next = cyc_inc ? 64'(mcycle_q + CYCLE_W'(1)) : mcycle_ext;
        if (do_write && sel_cyc_lo) begin
            cyc_next = {mcycle_ext[63:32], new_val};
        end else if (do_write && sel_cyc_hi) begin
            cyc_next = {new_val, mcycle_ext[31:0] + {31'd0, cyc_inc}};
        end

        ins_next = ins_inc ? 64'(minstret_q + INSTRET_W'(1)) : minstret_ext;
        if (do_write && sel_ins_lo) begin
            ins_next = {minstret_ext[63:32], new_val};
        end else if (do_write && sel_ins_hi) begin
            ins_next = {new_val, minstret_ext[31:0] + {31'd0, ins_inc}};
        end

        mcycle_d   = cyc_next[CYCLE_W-1:0];
        minstret_d = ins_next[INSTRET_W-1:0];
    end

    always_comb begin
        inh_cy_d = inh_cy_q;
        inh_ir_d = inh_ir_q;
        if (do_write && sel_inh) begin
            inh_cy_d = new_val[0];
            inh_ir_d = new_val[2];
        end
        valid_d = legal;
        rdata_d = legal ? old_val : 32'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            inh_cy_q   <= 1'b0;
            inh_ir_q   <= 1'b0;
            rdata_q    <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            inh_cy_q   <= inh_cy_d;
            inh_ir_q   <= inh_ir_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
        end
    end

    assign csr_rdata = rdata_q;
    assign csr_valid = valid_q;

endmodule

// File: tb/tb_csr_counter_responder.sv
// Bench for csr_counter_responder: 64-bit counter model checked every cycle,
// plus hand-computed expectations along a directed sequence.
module tb_csr_counter_responder;

    logic        clock;
    logic        reset;
    logic        retired;
    logic        csr_read;
    logic [2:0]  csr_modify;
    logic [31:0] csr_wdata;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata;
    logic        csr_valid;

    int n_total = 0;
    int n_pass  = 0;

    csr_counter_responder dut (
        .clock      (clock),
        .reset      (reset),
        .retired    (retired),
        .csr_read   (csr_read),
        .csr_modify (csr_modify),
        .csr_wdata  (csr_wdata),
        .csr_addr   (csr_addr),
        .csr_rdata  (csr_rdata),
        .csr_valid  (csr_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: full 64-bit counters, inhibit kept as the architectural 3-bit view.
    logic [63:0] m_cyc, m_ins;
    logic [2:0]  m_inh;
    logic [31:0] e_rdata;
    logic        e_valid;
    logic        live = 1'b0;

    always @(posedge clock) begin
        logic        wr, act, hit, ro, ok;
        logic [31:0] old, nv;
        logic [63:0] nc, ni, cinc, iinc;
        if (reset) begin
            m_cyc = 64'd0; m_ins = 64'd0; m_inh = 3'd0;
            e_valid = 1'b0; e_rdata = 32'd0; live = 1'b1;
        end else begin
            wr  = (csr_modify >= 3'd1) && (csr_modify <= 3'd3);
            act = csr_read || wr;
            hit = 1'b1; ro = 1'b0; old = 32'd0;
            case (csr_addr)
                12'hB00: old = m_cyc[31:0];
                12'hB80: old = m_cyc[63:32];
                12'hB02: old = m_ins[31:0];
                12'hB82: old = m_ins[63:32];
                12'h320: old = {29'd0, m_inh};
                12'hC00, 12'hC01: begin old = m_cyc[31:0];  ro = 1'b1; end
                12'hC80, 12'hC81: begin old = m_cyc[63:32]; ro = 1'b1; end
                12'hC02: begin old = m_ins[31:0];  ro = 1'b1; end
                12'hC82: begin old = m_ins[63:32]; ro = 1'b1; end
                default: hit = 1'b0;
            endcase
            ok = act && hit && !(ro && wr);
            e_valid = ok;
            e_rdata = ok ? old : 32'd0;
            cinc = m_inh[0] ? 64'd0 : 64'd1;
            iinc = (retired && !m_inh[2]) ? 64'd1 : 64'd0;
            nc = m_cyc + cinc;
            ni = m_ins + iinc;
            if (ok && wr) begin
                if (csr_modify == 3'd1)      nv = csr_wdata;
                else if (csr_modify == 3'd2) nv = old | csr_wdata;
                else                         nv = old & ~csr_wdata;
                case (csr_addr)
                    12'hB00: nc = (m_cyc & 64'hFFFF_FFFF_0000_0000) | {32'd0, nv};
                    12'hB80: nc = ({32'd0, nv} << 32) | ((m_cyc + cinc) & 64'h0000_0000_FFFF_FFFF);
                    12'hB02: ni = (m_ins & 64'hFFFF_FFFF_0000_0000) | {32'd0, nv};
                    12'hB82: ni = ({32'd0, nv} << 32) | ((m_ins + iinc) & 64'h0000_0000_FFFF_FFFF);
                    12'h320: m_inh = {nv[2], 1'b0, nv[0]};
                    default: ;
                endcase
            end
            m_cyc = nc;
            m_ins = ni;
        end
    end

    always @(negedge clock) begin
        if (live) begin
            check("model_valid", {31'd0, csr_valid}, {31'd0, e_valid});
            check("model_rdata", csr_rdata, e_rdata);
        end
    end

    task automatic cyc(input logic rd, input logic [2:0] md, input logic [31:0] wd,
                       input logic [11:0] ad, input logic ret);
        csr_read   = rd;
        csr_modify = md;
        csr_wdata  = wd;
        csr_addr   = ad;
        retired    = ret;
        @(negedge clock);
    endtask

    task automatic idle(input int n, input logic ret);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'd0, 12'h000, ret);
    endtask

    initial begin
        reset = 1'b1; retired = 1'b0; csr_read = 1'b0;
        csr_modify = 3'd0; csr_wdata = 32'd0; csr_addr = 12'd0;
        repeat (3) @(negedge clock);
        check("reset_valid", {31'd0, csr_valid}, 32'd0);
        check("reset_rdata", csr_rdata, 32'd0);

        // 1: free-running mcycle after reset
        reset = 1'b0;
        idle(10, 1'b0);
        cyc(1'b1, 3'd0, 32'd0, 12'hB00, 1'b0);
        check("t1_mcycle_valid", {31'd0, csr_valid}, 32'd1);
        check("t1_mcycle_lo", csr_rdata, 32'd10);
        cyc(1'b1, 3'd0, 32'd0, 12'hB80, 1'b0);
        check("t1_mcycle_hi", csr_rdata, 32'd0);

        // 2: carry from lo into hi
        cyc(1'b0, 3'd1, 32'hFFFF_FFFE, 12'hB00, 1'b0);
        check("t2_write_old", csr_rdata, 32'd12);
        idle(2, 1'b0);
        cyc(1'b1, 3'd0, 32'd0, 12'hB80, 1'b0);
        check("t2_carry_hi", csr_rdata, 32'd1);
        cyc(1'b1, 3'd0, 32'd0, 12'hB00, 1'b0);
        check("t2_after_lo", csr_rdata, 32'd1);

        // 3: instret inhibit
        cyc(1'b0, 3'd1, 32'd4, 12'h320, 1'b0);
        idle(5, 1'b1);
        cyc(1'b1, 3'd0, 32'd0, 12'hC02, 1'b0);
        check("t3_inhibited", csr_rdata, 32'd0);
        cyc(1'b1, 3'd3, 32'hFFFF_FFFF, 12'h320, 1'b0);
        check("t3_inhibit_old", csr_rdata, 32'd4);
        idle(3, 1'b1);
        cyc(1'b1, 3'd0, 32'd0, 12'hC02, 1'b0);
        check("t3_instret", csr_rdata, 32'd3);

        // 4: RO write, unmapped, reserved modify code, RO read
        cyc(1'b0, 3'd1, 32'hDEAD_BEEF, 12'hC00, 1'b0);
        check("t4_ro_write_valid", {31'd0, csr_valid}, 32'd0);
        check("t4_ro_write_rdata", csr_rdata, 32'd0);
        cyc(1'b1, 3'd0, 32'd0, 12'h7C0, 1'b0);
        check("t4_unmapped_valid", {31'd0, csr_valid}, 32'd0);
        cyc(1'b0, 3'd5, 32'd0, 12'hB00, 1'b0);
        check("t4_mod5_valid", {31'd0, csr_valid}, 32'd0);
        cyc(1'b1, 3'd0, 32'd0, 12'hC81, 1'b0);
        check("t4_timeh", csr_rdata, 32'd1);
        cyc(1'b1, 3'd1, 32'd0, 12'h7C0, 1'b0);

        // 5: set on minstret while retiring drops the increment
        cyc(1'b0, 3'd1, 32'd5, 12'hB02, 1'b0);
        cyc(1'b1, 3'd2, 32'h0000_0100, 12'hB02, 1'b1);
        check("t5_set_old", csr_rdata, 32'd5);
        cyc(1'b1, 3'd0, 32'd0, 12'hB02, 1'b0);
        check("t5_set_new", csr_rdata, 32'h105);

        // hi-word write with increment, 64-bit wrap, cycle inhibit
        cyc(1'b0, 3'd1, 32'hFFFF_FFFF, 12'hB80, 1'b0);
        cyc(1'b0, 3'd1, 32'hFFFF_FFFF, 12'hB00, 1'b0);
        cyc(1'b1, 3'd0, 32'd0, 12'hB80, 1'b0);
        check("wrap_hi_before", csr_rdata, 32'hFFFF_FFFF);
        cyc(1'b1, 3'd0, 32'd0, 12'hB80, 1'b0);
        check("wrap_hi_after", csr_rdata, 32'd0);
        cyc(1'b0, 3'd1, 32'hFFFF_FFFF, 12'h320, 1'b0);
        cyc(1'b1, 3'd0, 32'd0, 12'h320, 1'b0);
        check("inhibit_readback", csr_rdata, 32'd5);
        cyc(1'b1, 3'd0, 32'd0, 12'hB00, 1'b1);
        cyc(1'b1, 3'd0, 32'd0, 12'hB00, 1'b1);
        cyc(1'b0, 3'd1, 32'h0000_0007, 12'hB82, 1'b1);
        cyc(1'b1, 3'd0, 32'd0, 12'hC82, 1'b0);
        check("ins_hi_write", csr_rdata, 32'd7);
        cyc(1'b0, 3'd1, 32'd0, 12'h320, 1'b0);
        idle(2, 1'b1);

        // 6: reset mid-stream with a read pending
        reset = 1'b1;
        csr_read = 1'b1; csr_addr = 12'hB00; csr_modify = 3'd0; retired = 1'b1;
        @(negedge clock);
        check("t6_reset_valid", {31'd0, csr_valid}, 32'd0);
        check("t6_reset_rdata", csr_rdata, 32'd0);
        reset = 1'b0;
        cyc(1'b1, 3'd0, 32'd0, 12'hB00, 1'b0);
        check("t6_mcycle", csr_rdata, 32'd0);
        check("t6_valid", {31'd0, csr_valid}, 32'd1);
        cyc(1'b1, 3'd0, 32'd0, 12'hB02, 1'b0);
        check("t6_minstret", csr_rdata, 32'd0);
        idle(2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
